// File: rtl/cache_pkg.sv
// Shared types and sizing for the cache-to-bmem line adapters.
// The adapter is built from these constants rather than from module parameters.
package cache_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int BEAT_WIDTH = 64;
  localparam int BEATS      = 4;
  localparam int LINE_WIDTH = BEAT_WIDTH * BEATS;
  localparam int CNT_WIDTH  = $clog2(BEATS);
  localparam int LINE_BYTES = LINE_WIDTH / 8;

  typedef logic [LINE_WIDTH-1:0] line_t;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WR_BURST,
    DONE
  } adapter_state_t;

  // Clear the byte-offset bits so every bmem address names a whole line.
  function automatic logic [ADDR_WIDTH-1:0] line_align(input logic [ADDR_WIDTH-1:0] addr);
    return addr & ~ADDR_WIDTH'(LINE_BYTES - 1);
  endfunction

endpackage

// File: rtl/cacheline_adapter.sv
// Splits one cache's 256-bit line fill/writeback into 4-beat 64-bit bmem bursts.
// Read beats arrive on a shared bus; only beats tagged with our line address are kept.
module cacheline_adapter
  import cache_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] dfp_addr,
  input  logic                  dfp_read,
  input  logic                  dfp_write,
  input  line_t                 dfp_wdata,
  output line_t                 dfp_rdata,
  output logic                  dfp_resp,
  output logic [ADDR_WIDTH-1:0] bmem_addr,
  output logic                  bmem_read,
  output logic                  bmem_write,
  output logic [BEAT_WIDTH-1:0] bmem_wdata,
  input  logic                  bmem_ready,
  input  logic [ADDR_WIDTH-1:0] bmem_raddr,
  input  logic [BEAT_WIDTH-1:0] bmem_rdata,
  input  logic                  bmem_rvalid
);

  adapter_state_t        state, state_next;
  logic [CNT_WIDTH-1:0]  beat_cnt;
  logic [ADDR_WIDTH-1:0] addr_q;
  line_t                 wline;
  line_t                 rline;
  logic                  beat_match;
  logic                  last_beat;

  // Foreign traffic on the broadcast return bus is rejected here.
  assign beat_match = bmem_rvalid && (bmem_raddr == addr_q);
  assign last_beat  = (beat_cnt == CNT_WIDTH'(BEATS - 1));

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // NOTE: state_next gets a default before the case so no path can infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (dfp_write)     state_next = WR_BURST;
        else if (dfp_read) state_next = RD_REQ;
      end
      RD_REQ: begin
        if (bmem_ready) state_next = RD_WAIT;
      end
      RD_WAIT: begin
        if (beat_match && last_beat) state_next = DONE;
      end
      WR_BURST: begin
        if (bmem_ready && last_beat) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bmem_read  = 1'b0;
    bmem_write = 1'b0;
    bmem_wdata = '0;
    dfp_resp   = 1'b0;
    bmem_addr  = addr_q;
    dfp_rdata  = rline;
    case (state)
      RD_REQ:   bmem_read = 1'b1;
      WR_BURST: begin
        bmem_write = 1'b1;
        bmem_wdata = wline[BEAT_WIDTH*int'(beat_cnt) +: BEAT_WIDTH];
      end
      DONE:     dfp_resp = 1'b1;
      default:  ;
    endcase
  end

  // Address, beat counter and the assembled fill line; the fill line stays
  // visible on dfp_rdata until the next read overwrites its first beat.
  always_ff @(posedge clk) begin
    if (!rst) begin
      addr_q   <= '0;
      beat_cnt <= '0;
      rline    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (dfp_write || dfp_read) begin
            addr_q   <= line_align(dfp_addr);
            beat_cnt <= '0;
          end
        end
        RD_REQ: begin
          if (bmem_ready) beat_cnt <= '0;
        end
        RD_WAIT: begin
          if (beat_match) begin
            rline[BEAT_WIDTH*int'(beat_cnt) +: BEAT_WIDTH] <= bmem_rdata;
            beat_cnt <= beat_cnt + 1'b1;
          end
        end
        WR_BURST: begin
          if (bmem_ready) beat_cnt <= beat_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // NOTE: the writeback line is a pure data store with no reset; it is always
  // reloaded at accept before any beat of it is driven.
  always_ff @(posedge clk) begin
    if (state == IDLE && dfp_write) wline <= dfp_wdata;
  end

endmodule

// File: tb/tb_cacheline_adapter.sv
// Self-checking bench for cacheline_adapter: directed spec scenarios plus
// randomized read/write transactions checked against a line-level model.
module tb_cacheline_adapter;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [31:0]  dfp_addr = '0;
  logic         dfp_read = 1'b0;
  logic         dfp_write = 1'b0;
  logic [255:0] dfp_wdata = '0;
  logic [255:0] dfp_rdata;
  logic         dfp_resp;
  logic [31:0]  bmem_addr;
  logic         bmem_read;
  logic         bmem_write;
  logic [63:0]  bmem_wdata;
  logic         bmem_ready = 1'b0;
  logic [31:0]  bmem_raddr = '0;
  logic [63:0]  bmem_rdata = '0;
  logic         bmem_rvalid = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  cacheline_adapter dut (
    .clk         (clk),
    .rst         (rst),
    .dfp_addr    (dfp_addr),
    .dfp_read    (dfp_read),
    .dfp_write   (dfp_write),
    .dfp_wdata   (dfp_wdata),
    .dfp_rdata   (dfp_rdata),
    .dfp_resp    (dfp_resp),
    .bmem_addr   (bmem_addr),
    .bmem_read   (bmem_read),
    .bmem_write  (bmem_write),
    .bmem_wdata  (bmem_wdata),
    .bmem_ready  (bmem_ready),
    .bmem_raddr  (bmem_raddr),
    .bmem_rdata  (bmem_rdata),
    .bmem_rvalid (bmem_rvalid)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no end of test, expected $finish");
    $fatal(1, "watchdog expired");
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_read"},  bmem_read,  1'b0);
    check({tag, "_write"}, bmem_write, 1'b0);
    check({tag, "_addr"},  bmem_addr,  32'h0);
    check({tag, "_wdata"}, bmem_wdata, 64'h0);
    check({tag, "_resp"},  dfp_resp,   1'b0);
    check({tag, "_rdata"}, dfp_rdata,  256'h0);
  endtask

  // Line fill: the expected line is just the own-address beats in arrival order;
  // the response is due the cycle after the last own beat.
  task automatic do_read(input logic [31:0] addr, input int stall, input int max_foreign);
    logic [31:0]  own;
    logic [255:0] exp;
    logic [63:0]  d;
    int           nf;
    own = addr & ~32'h1F;
    exp = '0;
    dfp_addr   = addr;
    dfp_read   = 1'b1;
    bmem_ready = 1'b0;
    cyc();
    dfp_read = 1'b0;
    dfp_addr = $urandom;
    for (int s = 0; s <= stall; s++) begin
      check("rd_req_read", bmem_read, 1'b1);
      check("rd_req_addr", bmem_addr, own);
      check("rd_req_resp", dfp_resp, 1'b0);
      bmem_rvalid = 1'b1;
      bmem_raddr  = own;
      bmem_rdata  = {$urandom, $urandom};
      bmem_ready  = (s == stall);
      cyc();
    end
    check("rd_wait_read", bmem_read, 1'b0);
    for (int i = 0; i < 4; i++) begin
      nf = $urandom_range(0, max_foreign);
      for (int f = 0; f < nf; f++) begin
        if ($urandom_range(0, 2) == 0) begin
          bmem_rvalid = 1'b0;
          bmem_raddr  = own;
        end else begin
          bmem_rvalid = 1'b1;
          bmem_raddr  = own + 32 * $urandom_range(1, 1000);
        end
        bmem_rdata = {$urandom, $urandom};
        bmem_ready = 1'($urandom);
        cyc();
        check("rd_foreign_resp", dfp_resp, 1'b0);
      end
      d = {$urandom, $urandom};
      exp[64*i +: 64] = d;
      bmem_rvalid = 1'b1;
      bmem_raddr  = own;
      bmem_rdata  = d;
      cyc();
      check("rd_beat_resp", dfp_resp, (i == 3));
    end
    check("rd_rdata", dfp_rdata, exp);
    check("rd_done_read", bmem_read, 1'b0);
    bmem_rdata = {$urandom, $urandom};
    cyc();
    bmem_rvalid = 1'b0;
    check("rd_resp_pulse", dfp_resp, 1'b0);
    check("rd_rdata_stable", dfp_rdata, exp);
  endtask

  // Writeback: beat k on the bus must be slice k of the line, where k counts
  // ready-high cycles seen so far; response follows the fourth acceptance.
  task automatic do_write(input logic [31:0] addr, input logic [255:0] line,
                          input logic also_read, input logic use_pattern,
                          input logic [15:0] pattern);
    logic [31:0] own;
    logic        rdy;
    int          accepted;
    int          steps;
    own = addr & ~32'h1F;
    dfp_addr   = addr;
    dfp_wdata  = line;
    dfp_write  = 1'b1;
    dfp_read   = also_read;
    bmem_ready = 1'b0;
    cyc();
    dfp_write = 1'b0;
    dfp_read  = 1'b0;
    dfp_wdata = rand_line();
    dfp_addr  = $urandom;
    accepted = 0;
    steps    = 0;
    while (accepted < 4 && steps < 40) begin
      check("wr_write", bmem_write, 1'b1);
      check("wr_no_read", bmem_read, 1'b0);
      check("wr_addr", bmem_addr, own);
      check("wr_wdata", bmem_wdata, line[64*accepted +: 64]);
      check("wr_resp", dfp_resp, 1'b0);
      rdy = use_pattern ? pattern[steps % 16] : 1'($urandom);
      bmem_rvalid = 1'($urandom);
      bmem_raddr  = own;
      bmem_rdata  = {$urandom, $urandom};
      bmem_ready  = rdy;
      cyc();
      if (rdy) accepted++;
      steps++;
    end
    check("wr_bound", accepted, 4);
    check("wr_done_resp", dfp_resp, 1'b1);
    check("wr_done_write", bmem_write, 1'b0);
    bmem_rvalid = 1'b0;
    bmem_ready  = 1'b1;
    cyc();
    check("wr_resp_pulse", dfp_resp, 1'b0);
    check("wr_idle_read", bmem_read, 1'b0);
    cyc();
    check("wr_idle_read2", bmem_read, 1'b0);
    check("wr_idle_write", bmem_write, 1'b0);
  endtask

  initial begin
    rst = 1'b0;
    cyc();
    cyc();
    check_all_zero("reset");
    rst = 1'b1;
    cyc();
    check("idle_resp", dfp_resp, 1'b0);

    // Ideal read: beats land on cycles 2..5 after accept.
    do_read(32'h0000_1004, 0, 0);

    // Read with foreign beats interleaved between own beats.
    do_read(32'h0000_1000, 0, 2);

    // Write with ready pattern 1,0,1,1,0,1 then ready high.
    do_write(32'h0000_0040,
             {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
              64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA},
             1'b0, 1'b1, 16'hFFED);

    // Arbiter holds off the read request for ten cycles.
    do_read(32'h0000_5008, 10, 1);

    // Read and write raised together: the write burst runs, the read is dropped.
    do_write(32'h0000_7010, rand_line(), 1'b1, 1'b0, 16'h0);

    // Reset after two captured beats aborts the fill.
    dfp_addr   = 32'h0000_3000;
    dfp_read   = 1'b1;
    bmem_ready = 1'b1;
    cyc();
    dfp_read = 1'b0;
    cyc();
    for (int i = 0; i < 2; i++) begin
      bmem_rvalid = 1'b1;
      bmem_raddr  = 32'h0000_3000;
      bmem_rdata  = {$urandom, $urandom};
      cyc();
    end
    rst = 1'b0;
    cyc();
    check_all_zero("midrst");
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bmem_rdata = {$urandom, $urandom};
      cyc();
      check("late_resp", dfp_resp, 1'b0);
      check("late_rdata", dfp_rdata, 256'h0);
    end
    bmem_rvalid = 1'b0;
    do_read(32'h0000_3000, 1, 1);

    // Randomized mix of fills and writebacks.
    for (int t = 0; t < 12; t++) begin
      if ($urandom_range(0, 1) == 0)
        do_read($urandom, $urandom_range(0, 3), 2);
      else
        do_write($urandom, rand_line(), 1'($urandom), 1'b0, 16'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
